// File: rtl/axi_ram_wr_arb.sv
// axi_ram_wr_arb: two-requester, burst-locked arbiter for the RAM write-command port.
// A requester that wins keeps the port until its last=1 beat is accepted. At least
// one idle cycle separates consecutive bursts.
// Tie-break is fixed priority (requester 0). Define AXI_RAM_WR_ARB_RR_EN to make it
// round-robin, where the winner is the requester that was not granted last time.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s0_wr_cmd_*         requester 0 beat stream (payload, en, last in; ready out)
//   s1_wr_cmd_*         requester 1 beat stream (same as s0)
//   m_wr_cmd_*          merged beat stream to the RAM core (payload, en, last out; ready in)
//   grant_valid         a burst is currently granted
//   grant_sel           index of the granted (or most recently granted) requester
module axi_ram_wr_arb #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int AUSER_WIDTH = 1,
    parameter int WUSER_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [ID_WIDTH-1:0]    s0_wr_cmd_id,
    input  logic [ADDR_WIDTH-1:0]  s0_wr_cmd_addr,
    input  logic [AUSER_WIDTH-1:0] s0_wr_cmd_auser,
    input  logic [DATA_WIDTH-1:0]  s0_wr_cmd_data,
    input  logic [STRB_WIDTH-1:0]  s0_wr_cmd_strb,
    input  logic [WUSER_WIDTH-1:0] s0_wr_cmd_user,
    input  logic                   s0_wr_cmd_en,
    input  logic                   s0_wr_cmd_last,
    output logic                   s0_wr_cmd_ready,

    input  logic [ID_WIDTH-1:0]    s1_wr_cmd_id,
    input  logic [ADDR_WIDTH-1:0]  s1_wr_cmd_addr,
    input  logic [AUSER_WIDTH-1:0] s1_wr_cmd_auser,
    input  logic [DATA_WIDTH-1:0]  s1_wr_cmd_data,
    input  logic [STRB_WIDTH-1:0]  s1_wr_cmd_strb,
    input  logic [WUSER_WIDTH-1:0] s1_wr_cmd_user,
    input  logic                   s1_wr_cmd_en,
    input  logic                   s1_wr_cmd_last,
    output logic                   s1_wr_cmd_ready,

    output logic [ID_WIDTH-1:0]    m_wr_cmd_id,
    output logic [ADDR_WIDTH-1:0]  m_wr_cmd_addr,
    output logic [AUSER_WIDTH-1:0] m_wr_cmd_auser,
    output logic [DATA_WIDTH-1:0]  m_wr_cmd_data,
    output logic [STRB_WIDTH-1:0]  m_wr_cmd_strb,
    output logic [WUSER_WIDTH-1:0] m_wr_cmd_user,
    output logic                   m_wr_cmd_en,
    output logic                   m_wr_cmd_last,
    input  logic                   m_wr_cmd_ready,

    output logic                   grant_valid,
    output logic                   grant_sel
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state_reg, state_next;
    logic   busy_reg;
    logic   grant_reg, grant_next;
    logic   last_grant_reg, last_grant_next;
    logic   tie_winner;
    logic   sel_en;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign busy_reg = (state_reg == BURST);

    // Winner when both requesters are asking in the same idle cycle.
`ifdef AXI_RAM_WR_ARB_RR_EN
    assign tie_winner = ~last_grant_reg;
`else
    assign tie_winner = 1'b0;
`endif

    // Next-state logic; the grant is held through IDLE so the mux keeps pointing at the last winner.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        unique case (state_reg)
            IDLE: begin
                if (s0_wr_cmd_en && s1_wr_cmd_en) begin
                    grant_next = tie_winner;
                    state_next = BURST;
                end else if (s0_wr_cmd_en) begin
                    grant_next = 1'b0;
                    state_next = BURST;
                end else if (s1_wr_cmd_en) begin
                    grant_next = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (m_wr_cmd_en && m_wr_cmd_ready && m_wr_cmd_last) begin
                    state_next      = IDLE;
                    last_grant_next = grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload follows the granted requester at all times, with no register stage.
    assign m_wr_cmd_id    = grant_reg ? s1_wr_cmd_id    : s0_wr_cmd_id;
    assign m_wr_cmd_addr  = grant_reg ? s1_wr_cmd_addr  : s0_wr_cmd_addr;
    assign m_wr_cmd_auser = grant_reg ? s1_wr_cmd_auser : s0_wr_cmd_auser;
    assign m_wr_cmd_data  = grant_reg ? s1_wr_cmd_data  : s0_wr_cmd_data;
    assign m_wr_cmd_strb  = grant_reg ? s1_wr_cmd_strb  : s0_wr_cmd_strb;
    assign m_wr_cmd_user  = grant_reg ? s1_wr_cmd_user  : s0_wr_cmd_user;
    assign m_wr_cmd_last  = grant_reg ? s1_wr_cmd_last  : s0_wr_cmd_last;

    assign sel_en      = grant_reg ? s1_wr_cmd_en : s0_wr_cmd_en;
    assign m_wr_cmd_en = busy_reg && sel_en;

    // Ready reaches only the granted requester, and only while a burst is held.
    assign s0_wr_cmd_ready = busy_reg && !grant_reg && m_wr_cmd_ready;
    assign s1_wr_cmd_ready = busy_reg &&  grant_reg && m_wr_cmd_ready;

    assign grant_valid = busy_reg;
    assign grant_sel   = grant_reg;

endmodule

// File: doc/axi_ram_wr_arb.md
Name: axi_ram_wr_arb

Overview:
- Two-requester arbiter for the RAM write-command interface.
- Lets two AXI RAM write front-ends, each producing ram_wr_cmd_* beat streams, share one RAM write port.
- Grant is burst-locked: once a requester wins, it keeps the port until its beat with last=1 is accepted.
- Sits between the write front-ends and the RAM core; the RAM core sees a single write-command stream.

Parameters:
DATA_WIDTH, 32, RAM data width in bits
ADDR_WIDTH, 16, byte address width
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
ID_WIDTH, 8, transaction ID width
AUSER_WIDTH, 1, address-user sideband width
WUSER_WIDTH, 1, write-data-user sideband width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s0_wr_cmd_id  in  ID_WIDTH  requester 0 transaction ID
s0_wr_cmd_addr  in  ADDR_WIDTH  requester 0 beat byte address
s0_wr_cmd_auser  in  AUSER_WIDTH  requester 0 address user
s0_wr_cmd_data  in  DATA_WIDTH  requester 0 write data
s0_wr_cmd_strb  in  STRB_WIDTH  requester 0 byte strobes
s0_wr_cmd_user  in  WUSER_WIDTH  requester 0 data user
s0_wr_cmd_en  in  1  requester 0 beat valid
s0_wr_cmd_last  in  1  requester 0 final beat of burst
s0_wr_cmd_ready  out  1  requester 0 beat accepted
s1_wr_cmd_*  same widths/directions as s0_*  requester 1
m_wr_cmd_id/addr/auser/data/strb/user/en/last  out  widths as s0_*  to RAM
m_wr_cmd_ready  in  1  RAM accepts beat
grant_valid  out  1  a burst is currently granted
grant_sel  out  1  index of granted requester (0/1)

Behaviour:
- Beat transfer on a port: en && ready in the same cycle. Requesters may hold en high indefinitely; arbiter never asserts ready without a grant.
- Registers: busy_reg, grant_reg, last_grant_reg. Reset value of all three is 0.
- Outputs after reset: m_wr_cmd_en=0, s0/s1 ready=0, grant_valid=0, grant_sel=0.
- Output mapping:
  - grant_valid = busy_reg; grant_sel = grant_reg.
  - m payload fields (id, addr, auser, data, strb, user, last) are combinationally muxed from requester grant_reg at all times; payload is unregistered.
  - m_wr_cmd_en = busy_reg && en of the granted requester.
  - sX_wr_cmd_ready = busy_reg && grant_reg==X && m_wr_cmd_ready; the non-granted requester's ready is 0.
- State IDLE (busy_reg=0):
  - No requester en: stay IDLE.
  - Exactly one requester en: next cycle grant_reg=that index, busy_reg=1.
  - Both en: winner chosen per the Optional Feature.
  - Latency: first beat can transfer no earlier than 1 cycle after en rises.
- State BURST (busy_reg=1):
  - Beats pass through with zero added latency.
  - On a handshake with granted last=1: busy_reg<=0, last_grant_reg<=grant_reg. Next cycle is IDLE; one bubble cycle minimum between bursts.
  - Handshake with last=0, or no handshake: stay in BURST. No timeout.
  - Requests from the other requester are ignored until IDLE.
- grant_reg holds its value in IDLE, so grant_sel and the payload mux still point at the last winner.
- Single-beat bursts (last=1 on the first beat): grant for one handshake, then IDLE.
- Reset mid-burst: grant dropped and state returns to IDLE. The arbiter does not complete or flush the partial burst; the requester sees ready=0.
- m_wr_cmd_ready low: the granted beat stalls; the payload must stay stable as driven by the requester.

Optional Feature:
- Macro: AXI_RAM_WR_ARB_RR_EN.
- Defined: round-robin. When both requesters are en in IDLE, the winner is !last_grant_reg. After reset (last_grant_reg=0), requester 1 wins the first tie.
- Not defined: fixed priority. Requester 0 always wins a tie; last_grant_reg is still maintained but unused.

Test Plan:
- After reset, both requesters idle -> m_wr_cmd_en=0, both ready=0, grant_valid=0, grant_sel=0.
- s0 sends a 4-beat burst (addr 0x00,0x04,0x08,0x0C, last on beat 4), m_ready=1 -> grant_valid rises 1 cycle after en; 4 consecutive m handshakes with matching addr/data; grant_valid=0 on the following cycle.
- s0 and s1 both assert en in the same cycle with single-beat bursts, held continuously:
  - Without macro: order is s0, s0, s0...
  - With macro: grants alternate s1, s0, s1, with one bubble cycle between grants.
- s1 granted with 3-beat burst; s0 asserts en mid-burst; m_ready toggles 1,0,1,0,1 -> s0_ready stays 0 until s1's last is accepted; s1 beats complete only on m_ready=1 cycles; s0 is granted in the next arbitration.
- Reset asserted on beat 2 of a 5-beat s0 burst -> next cycle grant_valid=0, s0_ready=0, m_wr_cmd_en=0; after release, a new s0 request is re-arbitrated from IDLE.
- s1 single-beat burst with last=1, strb=0x3, m_ready=1 -> exactly one m handshake with m_wr_cmd_strb=0x3 and m_wr_cmd_id matching s1; returns to IDLE.
